// File: rtl/eth_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_tx_pkg
//  Description : Shared constants for the MAC transmit retry/backoff logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package eth_tx_pkg;

   // Backoff generator width, which is also the largest backoff exponent
   localparam int DEF_LFSR_W      = 10;
   // Nibbles per slot time (512 bit times)
   localparam int DEF_SLOT_NIB    = 128;
   // Nibble limit before a pending frame counts as excessively deferred
   localparam int DEF_EXDEFER_NIB = 6072;

   // Feedback taps of x^10 + x^3 + 1 (bit indices, XNOR feedback)
   localparam int LFSR_TAP_HI     = 9;
   localparam int LFSR_TAP_LO     = 2;

endpackage : eth_tx_pkg
`default_nettype wire

// File: rtl/eth_txretry_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : eth_txretry_lfsr
//  Description : Free-running backoff LFSR and exponent mask. Produces the
//                truncated random backoff value for the current retry count.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_txretry_lfsr
   import eth_tx_pkg::*;
#(
   parameter int LFSR_W = DEF_LFSR_W
) (
   input  logic              MTxClk,
   input  logic              Reset,
   input  logic [3:0]        retry_cnt,
   output logic [LFSR_W-1:0] random,
   output logic              random_eq0
);

   logic [LFSR_W-1:0] lfsr;
   logic [LFSR_W-1:0] mask;

   // Shift left every clock; XNOR feedback keeps all-zero legal and all-ones unreachable
   always_ff @(posedge MTxClk or posedge Reset) begin
      if (Reset)
         lfsr <= '0;
      else
         lfsr <= {lfsr[LFSR_W-2:0], ~(lfsr[LFSR_TAP_HI] ^ lfsr[LFSR_TAP_LO])};
   end

   // Bit i of the mask is open while i < retry count (width caps the exponent)
   generate
      for (genvar i = 0; i < LFSR_W; i++) begin : g_mask
         assign mask[i] = (int'(retry_cnt) > i);
      end
   endgenerate

   assign random     = lfsr & mask;
   assign random_eq0 = (random == '0);

endmodule : eth_txretry_lfsr
`default_nettype wire

// File: rtl/eth_txretry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : eth_txretry_ctrl
//  Description : Retry and backoff scheduler beside the MAC Tx state machine.
//                Owns the retry counter, backoff timer, collision window and
//                excessive-defer timer, and derives the Tx FSM qualifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_txretry_ctrl
   import eth_tx_pkg::*;
#(
   parameter int LFSR_W      = DEF_LFSR_W,
   parameter int SLOT_NIB    = DEF_SLOT_NIB,
   parameter int EXDEFER_NIB = DEF_EXDEFER_NIB
) (
   input  logic       MTxClk,
   input  logic       Reset,
   input  logic [3:0] MaxRet,
   input  logic [5:0] CollValid,
   input  logic       ExDfrEn,
   input  logic       TxStartFrm,
   input  logic       StateIdle,
   input  logic       StateDefer,
   input  logic       StatePreamble,
   input  logic       StateJam,
   input  logic       StateJam_q,
   input  logic       StateBackOff,
   input  logic       NibCntEq7,
   input  logic       StartTxDone,
   output logic [3:0] RetryCnt,
   output logic       RetryMax,
   output logic       RandomEq0,
   output logic       RandomEqByteCnt,
   output logic       ColWindow,
   output logic       ExcessiveDefer,
   output logic       RetryLimit
);

   localparam int SLOT_W  = $clog2(SLOT_NIB);
   localparam int DEFER_W = $clog2(EXDEFER_NIB);

   logic [LFSR_W-1:0]  random;
   logic [LFSR_W-1:0]  random_latched;
   logic [SLOT_W-1:0]  slot_nib;
   logic [LFSR_W-1:0]  slot_cnt;
   logic [6:0]         win_cnt;
   logic [DEFER_W-1:0] defer_cnt;
   logic               excessive_defer_q;
   logic               jam_start;
   logic               jam_decide;
   logic               ex_rise;
   logic               slot_wrap;
   logic               defer_active;
   logic               defer_at_limit;
   logic               unused_preamble;

   // Preamble is covered by "not idle/defer/backoff"; the input exists for interface completeness
   assign unused_preamble = StatePreamble;

   eth_txretry_lfsr #(
      .LFSR_W     (LFSR_W)
   ) u_lfsr (
      .MTxClk     (MTxClk),
      .Reset      (Reset),
      .retry_cnt  (RetryCnt),
      .random     (random),
      .random_eq0 (RandomEq0)
   );

   assign jam_start      = StateJam & ~StateJam_q;
   assign jam_decide     = StateJam & NibCntEq7;
   assign ex_rise        = ExcessiveDefer & ~excessive_defer_q;
   assign slot_wrap      = (slot_nib == SLOT_W'(SLOT_NIB - 1));
   assign defer_active   = StateDefer & TxStartFrm;
   assign defer_at_limit = (defer_cnt == DEFER_W'(EXDEFER_NIB - 1));

   assign RetryMax        = (RetryCnt >= MaxRet);
   assign RandomEqByteCnt = StateBackOff & slot_wrap & ((slot_cnt + LFSR_W'(1)) == random_latched);
   assign ColWindow       = (win_cnt < {CollValid, 1'b0});

   // Retry counter: bump on the first Jam cycle; any frame-ending event clears and wins
   always_ff @(posedge MTxClk or posedge Reset) begin
      if (Reset)
         RetryCnt <= '0;
      else if (StartTxDone || RetryLimit || ex_rise)
         RetryCnt <= '0;
      else if (jam_start && (RetryCnt != 4'hF))
         RetryCnt <= RetryCnt + 4'd1;
   end

   // Capture the backoff length and flag the retry abort at the Tx FSM's jam decision point
   always_ff @(posedge MTxClk or posedge Reset) begin
      if (Reset) begin
         random_latched <= '0;
         RetryLimit     <= 1'b0;
      end else begin
         if (jam_decide)
            random_latched <= random;
         RetryLimit <= jam_decide & RetryMax & ColWindow;
      end
   end

   // Backoff timer: nibbles within a slot, then slots; idle at zero outside Backoff
   always_ff @(posedge MTxClk or posedge Reset) begin
      if (Reset) begin
         slot_nib <= '0;
         slot_cnt <= '0;
      end else if (!StateBackOff) begin
         slot_nib <= '0;
         slot_cnt <= '0;
      end else begin
         slot_nib <= slot_wrap ? '0 : slot_nib + SLOT_W'(1);
         if (slot_wrap)
            slot_cnt <= slot_cnt + LFSR_W'(1);
      end
   end

   // Collision window: nibbles since the transmission attempt began, saturating
   always_ff @(posedge MTxClk or posedge Reset) begin
      if (Reset)
         win_cnt <= '0;
      else if (StateIdle || StateDefer || StateBackOff)
         win_cnt <= '0;
      else if (win_cnt != 7'h7F)
         win_cnt <= win_cnt + 7'd1;
   end

   // Excessive defer: count deferral of a pending frame, flag when the limit is hit
   always_ff @(posedge MTxClk or posedge Reset) begin
      if (Reset) begin
         defer_cnt         <= '0;
         ExcessiveDefer    <= 1'b0;
         excessive_defer_q <= 1'b0;
      end else begin
         if (!defer_active)
            defer_cnt <= '0;
         else if (!ExcessiveDefer && !defer_at_limit)
            defer_cnt <= defer_cnt + DEFER_W'(1);

         if (!TxStartFrm)
            ExcessiveDefer <= 1'b0;
         else if (defer_active && defer_at_limit && !ExDfrEn)
            ExcessiveDefer <= 1'b1;

         excessive_defer_q <= ExcessiveDefer;
      end
   end

endmodule : eth_txretry_ctrl
`default_nettype wire

// File: tb/tb_eth_txretry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_txretry_ctrl
//  Description : Scoreboard bench for eth_txretry_ctrl. Stimulus pushes the
//                expected outputs; a negedge monitor pops and compares them,
//                and matches every RetryLimit / RandomEqByteCnt pulse against
//                a queue of predicted pulse cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_txretry_ctrl;

   logic       MTxClk = 1'b0;
   logic       Reset = 1'b0;
   logic [3:0] MaxRet = 4'd0;
   logic [5:0] CollValid = 6'd0;
   logic       ExDfrEn = 1'b0;
   logic       TxStartFrm = 1'b0;
   logic       StateIdle = 1'b1;
   logic       StateDefer = 1'b0;
   logic       StatePreamble = 1'b0;
   logic       StateJam = 1'b0;
   logic       StateJam_q = 1'b0;
   logic       StateBackOff = 1'b0;
   logic       NibCntEq7 = 1'b0;
   logic       StartTxDone = 1'b0;
   logic [3:0] RetryCnt;
   logic       RetryMax;
   logic       RandomEq0;
   logic       RandomEqByteCnt;
   logic       ColWindow;
   logic       ExcessiveDefer;
   logic       RetryLimit;

   eth_txretry_ctrl dut (
      .MTxClk          (MTxClk),
      .Reset           (Reset),
      .MaxRet          (MaxRet),
      .CollValid       (CollValid),
      .ExDfrEn         (ExDfrEn),
      .TxStartFrm      (TxStartFrm),
      .StateIdle       (StateIdle),
      .StateDefer      (StateDefer),
      .StatePreamble   (StatePreamble),
      .StateJam        (StateJam),
      .StateJam_q      (StateJam_q),
      .StateBackOff    (StateBackOff),
      .NibCntEq7       (NibCntEq7),
      .StartTxDone     (StartTxDone),
      .RetryCnt        (RetryCnt),
      .RetryMax        (RetryMax),
      .RandomEq0       (RandomEq0),
      .RandomEqByteCnt (RandomEqByteCnt),
      .ColWindow       (ColWindow),
      .ExcessiveDefer  (ExcessiveDefer),
      .RetryLimit      (RetryLimit)
   );

   always #5 MTxClk = ~MTxClk;

   typedef enum int {S_RC, S_RMAX, S_REQ0, S_REQBC, S_COLW, S_EXDEF} sig_e;
   typedef struct {sig_e sig; int val; string name;} exp_t;
   typedef struct {int kind; int cyc;} pulse_t;   // kind 0 = RetryLimit, 1 = RandomEqByteCnt

   exp_t   exp_q[$];
   pulse_t pulse_q[$];
   int     cyc = 0;
   int     vectors = 0;
   int     miscompares = 0;
   logic [9:0] m_lfsr;

   // Golden backoff generator: x^10 + x^3 + 1, XNOR feedback, shift left
   always @(posedge MTxClk or posedge Reset) begin
      if (Reset) m_lfsr <= '0;
      else       m_lfsr <= {m_lfsr[8:0], ~(m_lfsr[9] ^ m_lfsr[2])};
   end

   always @(posedge MTxClk) cyc <= cyc + 1;

   function automatic int exp_req0(input logic [9:0] l, input int rc);
      logic [9:0] m;
      m = '0;
      for (int i = 0; i < 10; i++) if (i < rc) m[i] = 1'b1;
      return ((l & m) == 10'd0) ? 1 : 0;
   endfunction

   task automatic tick();
      @(posedge MTxClk);
      #1;
   endtask

   task automatic expect_sig(input sig_e s, input int v, input string nm);
      exp_t e;
      e.sig = s; e.val = v; e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic expect_pulse(input int kind, input int at);
      pulse_t p;
      p.kind = kind; p.cyc = at;
      pulse_q.push_back(p);
   endtask

   task automatic check_pulse(input int kind, input string nm);
      vectors++;
      if (pulse_q.size() > 0 && pulse_q[0].kind == kind && pulse_q[0].cyc == cyc) begin
         void'(pulse_q.pop_front());
      end else begin
         miscompares++;
         $display("FAIL %s: pulse seen at cycle %0d, required none at this cycle", nm, cyc);
      end
   endtask

   // Monitor: compare all queued expectations and any pulses at the falling edge
   always @(negedge MTxClk) begin
      exp_t e;
      int   act;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         case (e.sig)
            S_RC:    act = int'(RetryCnt);
            S_RMAX:  act = int'(RetryMax);
            S_REQ0:  act = int'(RandomEq0);
            S_REQBC: act = int'(RandomEqByteCnt);
            S_COLW:  act = int'(ColWindow);
            default: act = int'(ExcessiveDefer);
         endcase
         vectors++;
         if (act != e.val) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", e.name, cyc, act, e.val);
         end
      end
      while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
         vectors++;
         miscompares++;
         $display("FAIL pulse kind %0d missing: required at cycle %0d, got none", pulse_q[0].kind, pulse_q[0].cyc);
         void'(pulse_q.pop_front());
      end
      if (RetryLimit === 1'b1)      check_pulse(0, "retry_limit");
      if (RandomEqByteCnt === 1'b1) check_pulse(1, "random_eq_bytecnt");
   end

   task automatic jam_start_cycle();
      StatePreamble = 1'b0; StateIdle = 1'b0; StateBackOff = 1'b0;
      StateJam = 1'b1; StateJam_q = 1'b0;
   endtask

   initial begin
      int m_rl;
      int b1;
      int found;
      int waited;

      // ---------------- reset state ----------------
      #1 Reset = 1'b1;
      tick();
      expect_sig(S_RC, 0, "reset_retrycnt");
      expect_sig(S_RMAX, 1, "reset_retrymax_maxret0");
      expect_sig(S_REQ0, 1, "reset_randomeq0");
      expect_sig(S_REQBC, 0, "reset_randomeqbytecnt");
      expect_sig(S_COLW, 0, "reset_colwindow_cv0");
      expect_sig(S_EXDEF, 0, "reset_exdefer");
      tick();
      CollValid = 6'h05; MaxRet = 4'd2;
      expect_sig(S_COLW, 1, "reset_colwindow_cv5");
      expect_sig(S_RMAX, 0, "reset_retrymax_maxret2");

      // ---------------- long defer, no frame pending ----------------
      tick();
      Reset = 1'b0; MaxRet = 4'd15; CollValid = 6'h3F;
      StateIdle = 1'b0; StateDefer = 1'b1; TxStartFrm = 1'b0;
      for (int k = 0; k < 10000; k++) begin
         tick();
         expect_sig(S_RC, 0, "idle_defer_retrycnt");
         expect_sig(S_REQ0, 1, "idle_defer_randomeq0");
         expect_sig(S_EXDEF, 0, "idle_defer_exdefer");
      end

      // ---------------- first collision ----------------
      tick(); StateDefer = 1'b0; StatePreamble = 1'b1;
      tick(); tick();
      tick(); jam_start_cycle();
      expect_sig(S_RC, 0, "jam1_first_cycle_retrycnt");
      tick(); StateJam_q = 1'b1;
      expect_sig(S_RC, 1, "jam1_retrycnt");
      for (int k = 2; k <= 7; k++) begin
         tick();
         if (k == 7) begin
            NibCntEq7 = 1'b1;
            expect_sig(S_REQ0, exp_req0(m_lfsr, 1), "jam1_randomeq0_model");
            expect_sig(S_RC, 1, "jam1_nib7_retrycnt");
            expect_sig(S_RMAX, 0, "jam1_retrymax");
         end
      end
      m_rl = int'(m_lfsr[0]);
      tick(); NibCntEq7 = 1'b0; StateJam = 1'b0; StateBackOff = 1'b1;
      b1 = cyc;
      if (m_rl == 1) expect_pulse(1, b1 + 127);
      tick(); StateJam_q = 1'b0;
      for (int k = 0; k < 140; k++) tick();
      StateBackOff = 1'b0; StatePreamble = 1'b1;

      // ---------------- second collision, wait for random value 2 ----------------
      tick(); tick();
      tick(); jam_start_cycle();
      expect_sig(S_RC, 1, "jam2_first_cycle_retrycnt");
      tick(); StateJam_q = 1'b1;
      expect_sig(S_RC, 2, "jam2_retrycnt");
      found = 0; waited = 1;
      while (found == 0 && waited < 3000) begin
         tick();
         waited++;
         if (waited >= 7 && m_lfsr[1:0] == 2'b10) begin
            NibCntEq7 = 1'b1;
            found = 1;
            expect_sig(S_REQ0, 0, "jam2_randomeq0_rand2");
            expect_sig(S_RC, 2, "jam2_nib7_retrycnt");
         end else begin
            expect_sig(S_REQ0, exp_req0(m_lfsr, 2), "jam2_randomeq0_model");
         end
      end
      if (found == 0) begin
         vectors++; miscompares++;
         $display("FAIL jam2_wait: LFSR value 2 not reached in %0d cycles, required within 3000", waited);
      end
      tick(); NibCntEq7 = 1'b0; StateJam = 1'b0; StateBackOff = 1'b1;
      b1 = cyc;
      if (found == 1) expect_pulse(1, b1 + 255);
      tick(); StateJam_q = 1'b0;
      for (int k = 0; k < 300; k++) tick();
      StateBackOff = 1'b0; StateIdle = 1'b1; StartTxDone = 1'b1;
      expect_sig(S_RC, 2, "done_retrycnt_before_clear");
      tick(); StartTxDone = 1'b0;
      expect_sig(S_RC, 0, "done_retrycnt_cleared");

      // ---------------- retry limit with MaxRet = 3 ----------------
      MaxRet = 4'd3;
      for (int r = 1; r <= 3; r++) begin
         tick(); StateIdle = 1'b0; StatePreamble = 1'b1;
         tick();
         tick(); jam_start_cycle();
         tick(); StateJam_q = 1'b1;
         expect_sig(S_RC, r, "retry_round_retrycnt");
         for (int k = 2; k <= 7; k++) begin
            tick();
            if (r == 2 && k == 3) begin
               MaxRet = 4'd2;
               expect_sig(S_RMAX, 1, "maxret_change_retrymax_on");
            end
            if (r == 2 && k == 4) begin
               MaxRet = 4'd3;
               expect_sig(S_RMAX, 0, "maxret_change_retrymax_off");
            end
            if (k == 7) begin
               NibCntEq7 = 1'b1;
               expect_sig(S_RC, r, "retry_nib7_retrycnt");
               expect_sig(S_RMAX, (r >= 3) ? 1 : 0, "retry_nib7_retrymax");
               expect_sig(S_COLW, 1, "retry_nib7_colwindow");
               if (r == 3) expect_pulse(0, cyc + 1);
            end
         end
         tick(); NibCntEq7 = 1'b0; StateJam = 1'b0;
         if (r < 3) begin
            StateBackOff = 1'b1;
            tick(); StateJam_q = 1'b0;
            for (int k = 0; k < 10; k++) tick();
            StateBackOff = 1'b0;
         end else begin
            StateIdle = 1'b1;
            expect_sig(S_RC, 3, "limit_pulse_cycle_retrycnt");
            tick(); StateJam_q = 1'b0;
            expect_sig(S_RC, 0, "limit_retrycnt_cleared");
         end
      end

      // ---------------- collision window, CollValid = 0x20 ----------------
      CollValid = 6'h20; StateIdle = 1'b1;
      tick(); tick();
      tick(); StateIdle = 1'b0; StatePreamble = 1'b1;
      expect_sig(S_COLW, 1, "colwin_k0");
      for (int k = 1; k < 80; k++) begin
         tick();
         expect_sig(S_COLW, (k < 64) ? 1 : 0, "colwin_count");
      end
      tick(); StatePreamble = 1'b0; StateIdle = 1'b1;
      tick();
      expect_sig(S_COLW, 1, "colwin_back_on_idle");

      // ---------------- excessive defer, check enabled ----------------
      tick(); StateIdle = 1'b0; StateDefer = 1'b1; TxStartFrm = 1'b1; ExDfrEn = 1'b0;
      expect_sig(S_EXDEF, 0, "exdefer_k0");
      for (int k = 1; k <= 6080; k++) begin
         tick();
         expect_sig(S_EXDEF, (k >= 6072) ? 1 : 0, "exdefer_count");
      end
      expect_sig(S_RC, 0, "exdefer_retrycnt");
      tick(); TxStartFrm = 1'b0;
      expect_sig(S_EXDEF, 1, "exdefer_hold_on_abort_cycle");
      tick();
      expect_sig(S_EXDEF, 0, "exdefer_cleared_after_abort");

      // ---------------- excessive defer disabled, counter saturates ----------------
      tick(); TxStartFrm = 1'b1; ExDfrEn = 1'b1;
      for (int k = 0; k < 6200; k++) begin
         tick();
         expect_sig(S_EXDEF, 0, "exdefer_disabled");
      end
      ExDfrEn = 1'b0;
      expect_sig(S_EXDEF, 0, "exdefer_reenable_cycle");
      tick();
      expect_sig(S_EXDEF, 1, "exdefer_saturated_reenable");
      tick(); TxStartFrm = 1'b0;
      tick(); tick();
      expect_sig(S_EXDEF, 0, "exdefer_cleared_again");

      // ---------------- reset mid-count ----------------
      tick(); TxStartFrm = 1'b1;
      for (int k = 0; k < 3000; k++) tick();
      #2 Reset = 1'b1;
      expect_sig(S_EXDEF, 0, "midreset_exdefer");
      expect_sig(S_RC, 0, "midreset_retrycnt");
      expect_sig(S_REQ0, 1, "midreset_randomeq0");
      expect_sig(S_REQBC, 0, "midreset_randomeqbytecnt");
      tick(); tick();
      Reset = 1'b0;
      expect_sig(S_EXDEF, 0, "postreset_k0");
      for (int k = 1; k <= 6075; k++) begin
         tick();
         expect_sig(S_EXDEF, (k >= 6072) ? 1 : 0, "postreset_exdefer_count");
      end
      tick(); TxStartFrm = 1'b0; StateDefer = 1'b0; StateIdle = 1'b1;
      tick(); tick();

      while (pulse_q.size() > 0) begin
         vectors++; miscompares++;
         $display("FAIL pulse kind %0d missing: required at cycle %0d, got none", pulse_q[0].kind, pulse_q[0].cyc);
         void'(pulse_q.pop_front());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Watchdog: the whole run must end well inside this bound
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time %0t exceeded, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_eth_txretry_ctrl
`default_nettype wire
